// File: rtl/rom_read_arbiter.sv
// Shares one synchronous-read ROM port between NUM_REQ requesters.
// Round-robin or fixed-priority grant, in-order tagged responses.
module rom_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 24,
  parameter int RD_LAT  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fixed_prio,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [RD_LAT:0]   tag_vld_q, tag_vld_d;

  logic [RD_LAT:0][NUM_REQ-1:0] tag_id_q, tag_id_d;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [IDX_W-1:0]   gnt_idx;

  // Grant search: from index 0 in fixed mode, else from last+1 wrapping.
  always_comb begin
    int j;
    j       = 0;
    grant   = '0;
    found   = 1'b0;
    gnt_idx = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (fixed_prio) begin
        j = k;
      end else begin
        j = (int'(last_q) + 1 + k) % NUM_REQ;
      end
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = IDX_W'(j);
      end
    end
  end

  // Next state: issue address, shift tags, capture ROM data for the tail tag.
  always_comb begin
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    rsp_data_d = rsp_data_q;
    if (found) begin
      last_d     = gnt_idx;
      rom_addr_d = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    end
    tag_vld_d = {tag_vld_q[RD_LAT-1:0], found};
    tag_id_d  = {tag_id_q[RD_LAT-1:0], grant};
    // ROM data lines up with the tag one stage before the output stage.
    if (tag_vld_q[RD_LAT-1]) begin
      rsp_data_d = rom_dout;
    end
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q     <= LAST_RST;
      rom_addr_q <= '0;
      rsp_data_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      rsp_data_q <= rsp_data_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  assign req_ready = grant;
  assign rom_addr  = rom_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = tag_vld_q[RD_LAT] ? tag_id_q[RD_LAT] : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter (NUM_REQ=2, RD_LAT=1).
// Expected responses queue up at issue; a monitor pops them.
module tb_rom_read_arbiter;

  logic        clock;
  logic        reset;
  logic        fixed_prio;
  logic [1:0]  req_valid;
  logic [35:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic [17:0] rom_addr;
  logic [23:0] rom_dout;

  typedef struct {
    logic [1:0]  id;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rom_read_arbiter #(
    .NUM_REQ(2), .ADDR_W(18), .DATA_W(24), .RD_LAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fixed_prio(fixed_prio),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rom_addr(rom_addr),
    .rom_dout(rom_dout)
  );

  // ROM model: data for an address is valid one cycle after it is issued.
  assign rom_dout = {6'h0, rom_addr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One request cycle; checks the grant and queues the expected response.
  task automatic drive(input logic [1:0] v, input logic [17:0] a0,
                       input logic [17:0] a1, input logic fp,
                       input logic [1:0] er, input string nm);
    req_valid  = v;
    req_addr   = {a1, a0};
    fixed_prio = fp;
    @(negedge clock);
    chk(nm, 36'(req_ready), 36'(er));
    if (er[0]) sb.push_back('{id: 2'b01, data: {6'h0, a0}, due: cyc + 2});
    if (er[1]) sb.push_back('{id: 2'b10, data: {6'h0, a1}, due: cyc + 2});
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 18'h0, 18'h0, 1'b0, 2'b00, "idle_ready");
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_missing: got none, expected id %b data %h at cycle %0d",
                 sb[0].id, sb[0].data, sb[0].due);
        sb.delete(0);
      end
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %b data %h, expected none (cycle %0d)",
                   rsp_valid, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 36'(rsp_valid), 36'(e.id));
          chk("rsp_data", 36'(rsp_data), 36'(e.data));
          chk("rsp_latency", 36'(cyc), 36'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    fixed_prio = 1'b0;
    req_valid  = 2'b00;
    req_addr   = '0;
    #12;
    chk("rst_rom_addr", 36'(rom_addr), 36'h0);
    chk("rst_rsp_valid", 36'(rsp_valid), 36'h0);
    chk("rst_rsp_data", 36'(rsp_data), 36'h0);
    chk("rst_ready", 36'(req_ready), 36'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single request
    drive(2'b01, 18'h00123, 18'h0, 1'b0, 2'b01, "single_grant");
    chk("single_rom_addr", 36'(rom_addr), 36'h123);
    idle(3);

    // Round-robin contention from reset
    pulse_reset();
    drive(2'b11, 18'h10, 18'h20, 1'b0, 2'b01, "rr_g0");
    drive(2'b11, 18'h10, 18'h20, 1'b0, 2'b10, "rr_g1");
    drive(2'b11, 18'h10, 18'h20, 1'b0, 2'b01, "rr_g2");
    drive(2'b11, 18'h10, 18'h20, 1'b0, 2'b10, "rr_g3");

    // Fixed priority, then back to round-robin
    for (int i = 0; i < 3; i++)
      drive(2'b11, 18'h10, 18'h20, 1'b1, 2'b01, "fp_grant");
    drive(2'b11, 18'h10, 18'h20, 1'b0, 2'b10, "fp_then_rr");

    // Idle gap keeps rom_addr and the pointer
    drive(2'b01, 18'h3ABCD, 18'h0, 1'b0, 2'b01, "gap_hs");
    idle(4);
    chk("gap_rom_addr_hold", 36'(rom_addr), 36'h3ABCD);
    drive(2'b11, 18'h111, 18'h222, 1'b0, 2'b10, "gap_last_kept");
    idle(2);

    // Reset while a read is in flight
    drive(2'b01, 18'h155, 18'h0, 1'b0, 2'b01, "rst_hs");
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_rom_addr", 36'(rom_addr), 36'h0);
    chk("midrst_rsp_data", 36'(rsp_data), 36'h0);
    chk("midrst_rsp_valid", 36'(rsp_valid), 36'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3);
    drive(2'b11, 18'h0AA, 18'h0BB, 1'b0, 2'b01, "post_rst_prio");

    // Back-to-back single requester
    for (int i = 1; i <= 5; i++)
      drive(2'b10, 18'h0, 18'(i), 1'b0, 2'b10, "b2b_grant");
    idle(4);
    chk("sb_drained", 36'(sb.size()), 36'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
